// File: rtl/mic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mic_ctrl_pkg
// Shared widths, FSM state encodings and helpers for the PDM microphone ctrl.
// Revision: 1.0
// ============================================================================
package mic_ctrl_pkg;

  localparam int DIV_W     = 8;
  localparam int STARTUP_W = 16;
  localparam int DISCARD_W = 8;
  localparam int STATE_W   = 3;

  localparam logic [STATE_W-1:0] c_st_idle    = 3'd0;
  localparam logic [STATE_W-1:0] c_st_startup = 3'd1;
  localparam logic [STATE_W-1:0] c_st_settle  = 3'd2;
  localparam logic [STATE_W-1:0] c_st_run     = 3'd3;
  localparam logic [STATE_W-1:0] c_st_stop    = 3'd4;

  // States in which the microphone clock runs unconditionally
  function automatic logic is_active(input logic [STATE_W-1:0] st);
    return (st == c_st_startup) || (st == c_st_settle) || (st == c_st_run);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mic_ctrl_pdm_clk_gen.sv
`default_nettype none
// ============================================================================
// pdm_clk_gen
// Half-period divider producing the microphone clock and a pre-rise strobe.
// Revision: 1.0
// ============================================================================
module pdm_clk_gen
  import mic_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             pdm_clk,
  output logic             rise_pulse
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_pdm_clk;
  logic             w_wrap;

  assign w_wrap = en && (r_cnt == div);

  always_ff @(posedge clk_i) begin
    if (rst_i || !en) begin
      r_cnt     <= '0;
      r_pdm_clk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt     <= '0;
      r_pdm_clk <= ~r_pdm_clk;
    end else begin
      r_cnt     <= r_cnt + DIV_W'(1);
    end
  end

  // High in the cycle whose closing edge drives pdm_clk from low to high
  assign rise_pulse = w_wrap && !r_pdm_clk;
  assign pdm_clk    = r_pdm_clk;

endmodule
`default_nettype wire

// File: rtl/mic_ctrl.sv
`default_nettype none
// ============================================================================
// mic_ctrl
// PDM microphone sequencer: wake-up, sample discard, gated stream, clean stop.
// Revision: 1.0
// ============================================================================
module mic_ctrl
  import mic_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_W-1:0]     div_i,
  input  logic [STARTUP_W-1:0] startup_i,
  input  logic [DISCARD_W-1:0] discard_i,
  output logic                 pdm_clk_o,
  output logic                 sampler_en_o,
  input  logic                 sampler_data_i,
  input  logic                 sampler_valid_i,
  output logic                 data_o,
  output logic                 valid_o,
  output logic [STATE_W-1:0]   state_o
);

  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_nxt;
  logic [DIV_W-1:0]     r_div_q;
  logic [STARTUP_W-1:0] r_startup_q;
  logic [DISCARD_W-1:0] r_discard_q;
  logic [STARTUP_W-1:0] r_start_cnt;
  logic [DISCARD_W-1:0] r_disc_cnt;
  logic [STARTUP_W-1:0] w_start_cnt_nxt;
  logic [DISCARD_W:0]   w_disc_sum;
  logic                 w_startup_done;
  logic                 w_discard_done;
  logic                 w_gen_en;
  logic                 w_pdm_clk;
  logic                 w_rise;
  logic                 w_sampler_en_nxt;
  logic                 w_run_keep;
  logic                 r_sampler_en;
  logic                 r_data;
  logic                 r_valid;

  // In STOP the divider only runs to finish a high phase that is in flight
  assign w_gen_en = is_active(r_state) || ((r_state == c_st_stop) && w_pdm_clk);

  pdm_clk_gen u_pdm_clk_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en         (w_gen_en),
    .div        (r_div_q),
    .pdm_clk    (w_pdm_clk),
    .rise_pulse (w_rise)
  );

  assign w_start_cnt_nxt = (w_rise && !(&r_start_cnt)) ? r_start_cnt + STARTUP_W'(1)
                                                       : r_start_cnt;
  assign w_startup_done  = (w_start_cnt_nxt >= r_startup_q);
  // One spare bit so a 255-sample discard is compared before any wrap
  assign w_disc_sum      = {1'b0, r_disc_cnt} + {{DISCARD_W{1'b0}}, sampler_valid_i};
  assign w_discard_done  = (w_disc_sum == {1'b0, r_discard_q});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (en_i) w_state_nxt = c_st_startup;
      end
      c_st_startup: begin
        if (!en_i)               w_state_nxt = c_st_stop;
        else if (w_startup_done) w_state_nxt = (r_discard_q == '0) ? c_st_run : c_st_settle;
      end
      c_st_settle: begin
        if (!en_i)               w_state_nxt = c_st_stop;
        else if (w_discard_done) w_state_nxt = c_st_run;
      end
      c_st_run: begin
        if (!en_i) w_state_nxt = c_st_stop;
      end
      c_st_stop: begin
        if (!w_pdm_clk) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Stream passes only while RUN continues, so nothing leaks into STOP
  always_comb begin
    w_sampler_en_nxt = (w_state_nxt == c_st_settle) || (w_state_nxt == c_st_run);
    w_run_keep       = (r_state == c_st_run) && (w_state_nxt == c_st_run);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div_q     <= '0;
      r_startup_q <= '0;
      r_discard_q <= '0;
      r_start_cnt <= '0;
      r_disc_cnt  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_start_cnt <= '0;
          r_disc_cnt  <= '0;
          if (en_i) begin
            r_div_q     <= div_i;
            r_startup_q <= startup_i;
            r_discard_q <= discard_i;
          end
        end
        c_st_startup: r_start_cnt <= w_start_cnt_nxt;
        c_st_settle:  r_disc_cnt  <= w_disc_sum[DISCARD_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sampler_en <= 1'b0;
      r_data       <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_sampler_en <= w_sampler_en_nxt;
      r_data       <= w_run_keep && sampler_data_i;
      r_valid      <= w_run_keep && sampler_valid_i;
    end
  end

  assign pdm_clk_o    = w_pdm_clk;
  assign sampler_en_o = r_sampler_en;
  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign state_o      = r_state;

endmodule
`default_nettype wire

// File: doc/mic_ctrl.md
MIC_CTRL -- requirements
Module: mic_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Port clk_i  in  1  system clock; all logic SHALL be rising-edge clk_i.
REQ-003 Port rst_i  in  1  synchronous reset, active-high.
REQ-004 Port en_i  in  1  level request to run the microphone; low requests stop.
REQ-005 Port div_i  in  8  PDM half-period: pdm_clk_o toggles every div_i+1 clk_i cycles.
REQ-006 Port startup_i  in  16  mic wake time, in pdm_clk_o rising edges.
REQ-007 Port discard_i  in  8  number of initial sampler samples to drop.
REQ-008 Port pdm_clk_o  out  1  clock driven to the microphone and to the sampler's pdm_clk_i.
REQ-009 Port sampler_en_o  out  1  enable for the sampler.
REQ-010 Port sampler_data_i, sampler_valid_i  in  1 each  sampler stream input.
REQ-011 Port data_o, valid_o  out  1 each  gated PDM sample stream.
REQ-012 Port state_o  out  3  current FSM state encoding.

Function
REQ-013 The FSM SHALL have states IDLE=0, STARTUP=1, SETTLE=2, RUN=3 and STOP=4.
REQ-014 In IDLE: pdm_clk_o=0, sampler_en_o=0, divider and counters held at 0.
REQ-015 On IDLE with en_i=1: div_i, startup_i and discard_i latched; next state STARTUP. Config changes are ignored outside IDLE.
REQ-016 Divider behaviour in STARTUP/SETTLE/RUN:
- counts 0..div_q;
- at div_q, pdm_clk_o toggles and the counter wraps to 0;
- first toggle (low->high) occurs div_q+1 cycles after entering STARTUP.
REQ-017 STARTUP SHALL count pdm_clk_o rising edges. On the cycle the count reaches startup_q, it SHALL exit to SETTLE, or to RUN if discard_q=0. startup_q=0 exits after one cycle.
REQ-018 sampler_en_o SHALL be 1 in SETTLE and RUN only, registered from the state.
REQ-019 SETTLE SHALL count sampler_valid_i pulses and enter RUN on the cycle the count reaches discard_q. Discarded samples never appear on valid_o.
REQ-020 Output stream in RUN:
- data_o = sampler_data_i registered, valid_o = sampler_valid_i registered;
- latency 1 cycle;
- both outputs are 0 in every other state.
REQ-021 en_i=0 in STARTUP/SETTLE/RUN SHALL move to STOP next cycle.
REQ-022 STOP behaviour:
- sampler_en_o=0 and valid_o=0 from the first STOP cycle;
- the divider keeps running until pdm_clk_o is low;
- then next state IDLE.
- A high phase is never truncated.
- If pdm_clk_o is already low, STOP lasts one cycle.
REQ-023 en_i=1 during STOP SHALL be ignored; restart only from IDLE.
REQ-024 The startup counter SHALL saturate. The discard counter SHALL be 8 bits and never wrap before comparison.
REQ-025 sampler_valid_i in the same cycle as the SETTLE->RUN transition SHALL be counted as discarded.

Reset
REQ-026 rst_i=1 SHALL force, on the next edge:
- state IDLE;
- pdm_clk_o=0, sampler_en_o=0, data_o=0, valid_o=0;
- all counters and latched config to 0.
REQ-027 Reset mid-operation (any state) SHALL take effect in one cycle regardless of pdm_clk_o phase; truncation is permitted only under reset.

Structure
REQ-028 State encodings, the DIV_W=8, STARTUP_W=16 and DISCARD_W=8 widths SHALL reside in shared package mic_ctrl_pkg.
REQ-029 The divider/toggle logic SHALL be a sub-module pdm_clk_gen (inputs: en, div; outputs: pdm_clk, rise_pulse).
REQ-030 The block SHALL be instantiated alongside sampler in the DFE front end. Its pdm_clk_o feeds the sampler's pdm_clk_i and its sampler_en_o feeds the sampler's en_i.

Verification
REQ-031 Bring-up: div_i=1, startup_i=4, discard_i=3, en_i=1 with a sampler model.
- pdm_clk_o period = 4 cycles;
- SETTLE entered on the 4th rising edge;
- first valid_o is the 4th sampler pulse + 1 cycle.
REQ-032 Zero config: div_i=0, startup_i=0, discard_i=0.
- STARTUP lasts 1 cycle, then RUN;
- pdm_clk_o toggles every cycle.
REQ-033 Clean stop: drop en_i while pdm_clk_o is high with div_i=3.
- pdm_clk_o stays high for its full 4 cycles;
- IDLE follows;
- valid_o=0 from the first STOP cycle.
REQ-034 Reset mid-RUN: assert rst_i for 1 cycle with pdm_clk_o=1.
- Next cycle: all outputs 0 and state_o=0.
REQ-035 Config isolation: change div_i from 1 to 5 during RUN.
- The period remains 4 cycles until the next IDLE->STARTUP.
REQ-036 Discard boundary: discard_i=255.
- Exactly 255 sampler pulses are dropped;
- the 256th appears on valid_o.
